// File: rtl/pipe_skid_pkg.sv
// pipe_skid_pkg: shared definitions for the two-entry registered skid stage.
//   state_t            - stage occupancy state (EMPTY/BUSY/FULL, 2-bit)
//   RST_ACTIVE         - level of rst that holds the stage in reset
//   DEFAULT_DATA_WIDTH - default payload width
package pipe_skid_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic        RST_ACTIVE         = 1'b0;
  localparam int unsigned DEFAULT_DATA_WIDTH = 32;

endpackage

// File: rtl/pipe_skid_if.sv
// pipe_skid_if: one valid/ready channel.
//   valid - producer presents data
//   data  - payload, DATA_WIDTH bits
//   ready - consumer accepts
// master = producer side, slave = consumer side.
interface pipe_skid_if
  import pipe_skid_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

  logic                  valid;
  logic [DATA_WIDTH-1:0] data;
  logic                  ready;

  modport master (output valid, output data, input  ready);
  modport slave  (input  valid, input  data, output ready);

endinterface

// File: rtl/pipe_skid.sv
// pipe_skid: two-entry valid/ready stage that registers both directions.
// pout.valid/pout.data and pin.ready all come from flops, so there is no
// combinational path from pout.ready to pin.ready.
//   clk       - core clock, all state changes on posedge
//   rst       - asynchronous reset, active-low
//   flush     - synchronous kill of all held entries (highest priority)
//   pin       - upstream channel (slave): valid/data in, ready out
//   pout      - downstream channel (master): valid/data out, ready in;
//               data is forced to zero while valid is low
//   occupancy - number of held entries (0..2)
module pipe_skid
  import pipe_skid_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  pipe_skid_if.slave       pin,
  pipe_skid_if.master      pout,
  output logic [1:0]       occupancy
);

  state_t                r_state;
  state_t                w_next;
  logic                  r_valid;
  logic                  r_ready;
  logic [DATA_WIDTH-1:0] r_main;
  logic [DATA_WIDTH-1:0] r_skid;

  logic w_in_fire;
  logic w_out_fire;
  logic w_load_main;
  logic w_main_from_skid;
  logic w_load_skid;

  assign w_in_fire  = pin.valid & r_ready;
  assign w_out_fire = r_valid & pout.ready;

  always_comb begin
    w_next           = r_state;
    w_load_main      = 1'b0;
    w_main_from_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      w_next = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_load_main = 1'b1;
            w_next      = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_in_fire && w_out_fire) begin
            w_load_main = 1'b1;
          end else if (w_in_fire) begin
            w_load_skid = 1'b1;
            w_next      = ST_FULL;
          end else if (w_out_fire) begin
            w_next = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // pin.ready is low here, so only the drain side can move.
          if (w_out_fire) begin
            w_load_main      = 1'b1;
            w_main_from_skid = 1'b1;
            w_next           = ST_BUSY;
          end
        end
        default: w_next = ST_EMPTY;
      endcase
    end
  end

  // valid/ready are registered copies of decodes of the next state so
  // both handshake outputs leave straight from flops.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      r_state <= ST_EMPTY;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_next;
      r_valid <= (w_next != ST_EMPTY);
      r_ready <= (w_next != ST_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (w_load_main) r_main <= w_main_from_skid ? r_skid : pin.data;
    if (w_load_skid) r_skid <= pin.data;
  end

  assign pin.ready  = r_ready;
  assign pout.valid = r_valid;
  assign pout.data  = r_valid ? r_main : '0;
  assign occupancy  = r_state;

  a_hold_stable: assert property (@(posedge clk) disable iff (rst == RST_ACTIVE)
    (r_valid && !pout.ready && !flush) |=> (r_valid && r_main == $past(r_main)));

  a_occ_max: assert property (@(posedge clk) disable iff (rst == RST_ACTIVE)
    occupancy != 2'd3);

  a_ready_full: assert property (@(posedge clk) disable iff (rst == RST_ACTIVE)
    !r_ready |-> (r_state == ST_FULL));

endmodule
